// File: rtl/bist_sequencer_if.sv
// Control/status bundle between a BIST sequencer and whatever drives it.
// The master side requests runs and reports per-channel failures; the slave side
// (the sequencer) reports its state, the channel under test and the sticky results.
interface bist_sequencer_if #(
    parameter int unsigned N_CHAN = 4
);
    localparam int unsigned SelW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    logic              bist_start;
    logic [N_CHAN-1:0] chan_enable;
    logic [N_CHAN-1:0] chan_fail;
    logic              mode;
    logic              init;
    logic              running;
    logic              finish;
    logic              bist_end;
    logic [SelW-1:0]   chan_sel;
    logic [N_CHAN-1:0] fail_mask;
    logic              pass;

    modport master (
        output bist_start, chan_enable, chan_fail,
        input  mode, init, running, finish, bist_end, chan_sel, fail_mask, pass
    );

    modport slave (
        input  bist_start, chan_enable, chan_fail,
        output mode, init, running, finish, bist_end, chan_sel, fail_mask, pass
    );
endinterface

// File: rtl/bist_sequencer.sv
// Steps through the enabled BIST channels in ascending order, spending a fixed
// number of cycles in INIT and then RUN on each, and collects a sticky fail mask
// from the RUN phase of every channel. All outputs decode registered state only.
module bist_sequencer #(
    parameter int unsigned N_CHAN      = 4,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned RUN_CYCLES  = 4
) (
    input logic             clock,
    input logic             reset,
    bist_sequencer_if.slave bus
);
    localparam int unsigned SelW      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int unsigned MaxCycles = (INIT_CYCLES > RUN_CYCLES) ? INIT_CYCLES : RUN_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    // Counter counts down to zero, so a phase of L cycles loads L-1.
    localparam logic [CntW-1:0] InitLoad = CntW'(INIT_CYCLES - 1);
    localparam logic [CntW-1:0] RunLoad  = CntW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StInit, StRun, StFinish} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [N_CHAN-1:0] en_q, en_d;
    logic [N_CHAN-1:0] fail_q, fail_d;
    logic              bist_end_q, bist_end_d;

    logic              first_found, next_found;
    logic [SelW-1:0]   first_idx, next_idx;

    // Priority scans: lowest requested channel at start, next-higher latched channel later.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = int'(N_CHAN) - 1; i >= 0; i--) begin
            if (bus.chan_enable[i]) begin
                first_found = 1'b1;
                first_idx   = SelW'(i);
            end
            if (en_q[i] && (i > int'(sel_q))) begin
                next_found = 1'b1;
                next_idx   = SelW'(i);
            end
        end
    end

    // Next-state logic for the sequencer FSM, counter, channel pointer and results.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        en_d       = en_q;
        fail_d     = fail_q;
        bist_end_d = 1'b0;
        case (state_q)
            StIdle: begin
                sel_d = '0;
                if (bus.bist_start) begin
                    en_d   = bus.chan_enable;
                    fail_d = '0;
                    if (first_found) begin
                        state_d = StInit;
                        sel_d   = first_idx;
                        cnt_d   = InitLoad;
                    end else begin
                        state_d    = StFinish;
                        cnt_d      = '0;
                        bist_end_d = 1'b1;
                    end
                end
            end
            StInit: begin
                if (cnt_q == '0) begin
                    state_d = StRun;
                    cnt_d   = RunLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRun: begin
                if (bus.chan_fail[sel_q]) begin
                    fail_d[sel_q] = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (next_found) begin
                        state_d = StInit;
                        sel_d   = next_idx;
                        cnt_d   = InitLoad;
                    end else begin
                        // chan_sel stays on the last tested channel
                        state_d    = StFinish;
                        cnt_d      = '0;
                        bist_end_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFinish: begin
                if (!bus.bist_start) begin
                    state_d = StIdle;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over any request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= '0;
            en_q       <= '0;
            fail_q     <= '0;
            bist_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            fail_q     <= fail_d;
            bist_end_q <= bist_end_d;
        end
    end

    assign bus.mode      = (state_q != StIdle);
    assign bus.init      = (state_q == StInit);
    assign bus.running   = (state_q == StRun);
    assign bus.finish    = (state_q == StFinish);
    assign bus.bist_end  = bist_end_q;
    assign bus.chan_sel  = sel_q;
    assign bus.fail_mask = fail_q;
    assign bus.pass      = (state_q == StFinish) && (fail_q == '0);
endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: each run's expected outcome (duration, channel order,
// fail mask, pass) is derived from the enable and per-cycle fail table and queued;
// a monitor observes the DUT and checks each completed run against the queue.
module tb_bist_sequencer;
    localparam int NCH = 4;
    localparam int IC  = 2;
    localparam int RC  = 4;
    localparam int CYC = IC + RC;

    typedef struct {
        logic [3:0]  mask;
        logic        pass;
        int          dur;
        int          nch;
        logic [63:0] seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bist_sequencer_if #(.N_CHAN(NCH)) bus ();

    bist_sequencer #(
        .N_CHAN      (NCH),
        .INIT_CYCLES (IC),
        .RUN_CYCLES  (RC)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    logic [3:0] fail_tbl[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: channel c is in RUN during cycles k*CYC+IC .. k*CYC+CYC-1 of slot k.
    function automatic exp_t model(input logic [3:0] en);
        exp_t e;
        logic [3:0] ch;
        e.mask = '0;
        e.nch  = 0;
        e.seq  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (en[c]) begin
                e.seq[e.nch*4 +: 4] = 4'(c);
                e.nch++;
            end
        end
        e.dur = e.nch * CYC;
        for (int k = 0; k < e.nch; k++) begin
            ch = e.seq[k*4 +: 4];
            for (int p = IC; p < CYC; p++) begin
                if (fail_tbl[k*CYC + p][ch]) e.mask[ch] = 1'b1;
            end
        end
        e.pass = (e.mask == 4'b0000);
        return e;
    endfunction

    // Full run from IDLE: start, noisy inputs during the run, hold FINISH, release.
    task automatic do_run(input logic [3:0] en, input int hold);
        exp_t e;
        int   j;
        e = model(en);
        exp_q.push_back(e);
        bus.chan_enable = en;
        bus.bist_start  = 1'b1;
        bus.chan_fail   = 4'($urandom);
        tick();
        j = 0;
        while (!bus.finish && j < 100) begin
            bus.chan_fail   = fail_tbl[j % 64];
            bus.chan_enable = 4'($urandom);
            bus.bist_start  = (j >= e.dur - 1) ? 1'b1 : 1'($urandom);
            tick();
            j++;
        end
        if (j >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: got no finish after %0d cycles, expected %0d", j, e.dur);
        end
        bus.bist_start = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.chan_fail   = 4'($urandom);
            bus.chan_enable = 4'($urandom);
            tick();
            check("finish_hold", bus.finish, 1'b1);
            check("mask_hold", bus.fail_mask, e.mask);
            check("pass_hold", bus.pass, e.pass);
        end
        bus.bist_start = 1'b0;
        tick();
        check("idle_mode", bus.mode, 1'b0);
        check("idle_sel", bus.chan_sel, 2'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mode"}, bus.mode, 1'b0);
        check({tag, "_init"}, bus.init, 1'b0);
        check({tag, "_running"}, bus.running, 1'b0);
        check({tag, "_finish"}, bus.finish, 1'b0);
        check({tag, "_bist_end"}, bus.bist_end, 1'b0);
        check({tag, "_pass"}, bus.pass, 1'b0);
        check({tag, "_chan_sel"}, bus.chan_sel, 2'd0);
        check({tag, "_fail_mask"}, bus.fail_mask, 4'd0);
    endtask

    // Monitor: tracks run start, INIT channel order, and checks each bist_end.
    initial begin : monitor
        int          cyc = 0;
        int          start_cyc = 0;
        int          seq_n = 0;
        logic [63:0] seq = '0;
        logic        mode_p = 1'b0;
        logic        init_p = 1'b0;
        logic        end_p = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (bus.mode === 1'b1 && !mode_p) begin
                start_cyc = cyc;
                seq_n     = 0;
                seq       = '0;
            end
            if (bus.init === 1'b1 && !init_p && seq_n < 16) begin
                seq[seq_n*4 +: 4] = 4'(bus.chan_sel);
                seq_n++;
            end
            if (end_p) check("bist_end_width", bus.bist_end, 1'b0);
            if (bus.bist_end === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_bist_end: got pulse, expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("duration", 64'(cyc - start_cyc), 64'(e.dur));
                    check("chan_count", 64'(seq_n), 64'(e.nch));
                    check("chan_order", seq, e.seq);
                    check("fail_mask", bus.fail_mask, e.mask);
                    check("pass", bus.pass, e.pass);
                    check("finish_at_end", bus.finish, 1'b1);
                end
            end
            mode_p = (bus.mode === 1'b1);
            init_p = (bus.init === 1'b1);
            end_p  = (bus.bist_end === 1'b1);
            cyc++;
        end
    end

    initial begin : stimulus
        int w;
        // Reset held two cycles with a start request pending: reset wins.
        bus.bist_start  = 1'b1;
        bus.chan_enable = 4'b1111;
        bus.chan_fail   = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        bus.bist_start = 1'b0;
        bus.chan_fail  = '0;
        tick();

        // All channels, no fails.
        for (int j = 0; j < 64; j++) fail_tbl[j] = '0;
        do_run(4'b1111, 3);

        // Channels 0 and 2, channel 2 fails in its third RUN cycle.
        for (int j = 0; j < 64; j++) fail_tbl[j] = '0;
        fail_tbl[CYC + IC + 2] = 4'b0100;
        do_run(4'b0101, 2);

        // Fails on a channel not under test and during INIT are ignored.
        for (int j = 0; j < 64; j++) fail_tbl[j] = '0;
        fail_tbl[0] = 4'b0001;
        fail_tbl[1] = 4'b0001;
        for (int j = IC; j < CYC; j++) fail_tbl[j] = 4'b0010;
        do_run(4'b0011, 1);

        // Leave a failing result, then an empty run must report a clean mask.
        for (int j = 0; j < 64; j++) fail_tbl[j] = 4'b1111;
        do_run(4'b1010, 1);
        do_run(4'b0000, 10);
        do_run(4'b0110, 1);

        // Reset while channel 1 is in RUN.
        for (int j = 0; j < 64; j++) fail_tbl[j] = '0;
        bus.chan_enable = 4'b1111;
        bus.bist_start  = 1'b1;
        w = 0;
        tick();
        while (!(bus.running === 1'b1 && bus.chan_sel == 2'd1) && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL reach_chan1_run: got timeout after %0d cycles, expected RUN on 1", w);
        end
        rst = 1'b1;
        tick();
        check_all_zero("midrun_reset");
        rst = 1'b0;
        bus.bist_start = 1'b0;
        tick();
        do_run(4'b1111, 1);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            for (int j = 0; j < 64; j++) fail_tbl[j] = 4'($urandom) & 4'($urandom) & 4'($urandom);
            do_run(4'($urandom), 1 + int'($urandom_range(3)));
        end

        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 SHALL have parameter N_CHAN, default 4: number of BIST channels, legal 1..16.
REQ-002 SHALL have parameter INIT_CYCLES, default 2: cycles spent in INIT per channel, legal >=1.
REQ-003 SHALL have parameter RUN_CYCLES, default 4: cycles spent in RUN per channel, legal >=1.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port bist_start  input  1  level request to start a BIST sequence.
REQ-007 SHALL have port chan_enable  input  N_CHAN  per-channel enable, sampled at start.
REQ-008 SHALL have port chan_fail  input  N_CHAN  per-channel fail indication from the tested logic.
REQ-009 SHALL have port mode  output  1  high whenever state is not IDLE.
REQ-010 SHALL have ports init, running, finish  output  1 each  high in INIT, RUN, FINISH respectively.
REQ-011 SHALL have port bist_end  output  1  one-cycle pulse on entry to FINISH.
REQ-012 SHALL have port chan_sel  output  max(1,clog2(N_CHAN))  index of the channel under test.
REQ-013 SHALL have port fail_mask  output  N_CHAN  sticky per-channel fail result.
REQ-014 SHALL have port pass  output  1  high in FINISH when fail_mask is all zero.

Function
REQ-015 SHALL implement states IDLE, INIT, RUN, FINISH; all outputs decoded from registers (no combinational path from inputs to outputs).
REQ-016 SHALL, in IDLE with bist_start=1, latch chan_enable into an internal enable register, clear fail_mask, and move to INIT on the lowest enabled channel at the next edge.
REQ-017 SHALL, when the latched enable is all zero at start, move IDLE -> FINISH directly, with fail_mask=0 and pass=1.
REQ-018 SHALL remain in INIT exactly INIT_CYCLES cycles, then enter RUN for the same channel.
REQ-019 SHALL remain in RUN exactly RUN_CYCLES cycles, then enter INIT for the next-higher enabled channel, or FINISH if none remains.
REQ-020 SHALL skip disabled channels with zero cycle cost; a run with E enabled channels takes E*(INIT_CYCLES+RUN_CYCLES) cycles from leaving IDLE to entering FINISH.
REQ-021 SHALL set fail_mask[chan_sel] on any RUN cycle where chan_fail[chan_sel]=1; the bit SHALL stay set until the next start or reset.
REQ-022 SHALL ignore chan_fail bits of channels not currently in RUN, and all of chan_fail during INIT.
REQ-023 SHALL ignore changes of chan_enable and bist_start after the start, until FINISH.
REQ-024 SHALL hold FINISH (finish=1, fail_mask and pass stable) while bist_start=1, and return to IDLE on the first cycle bist_start=0.
REQ-025 SHALL require bist_start to drop before a new run starts; no back-to-back restart from FINISH.
REQ-026 SHALL hold chan_sel at 0 in IDLE, and hold it at the last tested channel in FINISH.
REQ-027 SHALL use an internal cycle counter wide enough for max(INIT_CYCLES,RUN_CYCLES), reloaded on every state entry, with no wrap-around.

Reset
REQ-028 SHALL, on reset=1 at a clock edge (including mid-sequence), enter IDLE with mode, init, running, finish, bist_end, pass=0, chan_sel=0, fail_mask=0, counter=0.
REQ-029 SHALL give reset priority over bist_start in the same cycle.

Verification (N_CHAN=4, INIT_CYCLES=2, RUN_CYCLES=4)
REQ-030 SHALL cover: reset held 2 cycles -> all outputs 0, chan_sel=0.
REQ-031 SHALL cover: chan_enable=4'b1111, no fails, bist_start=1 -> chan_sel 0,1,2,3; FINISH entered 24 cycles after leaving IDLE; bist_end high exactly 1 cycle; pass=1; fail_mask=0.
REQ-032 SHALL cover: chan_enable=4'b0101, chan_fail[2]=1 in the 3rd RUN cycle of channel 2 -> chan_sel 0 then 2; FINISH after 12 cycles; fail_mask=4'b0100; pass=0.
REQ-033 SHALL cover: chan_fail[1]=1 while channel 0 is in RUN, and chan_fail[0]=1 during channel 0 INIT -> fail_mask=0, pass=1.
REQ-034 SHALL cover: chan_enable=0, bist_start=1 -> FINISH next cycle, bist_end pulse, pass=1; bist_start kept high 10 cycles -> stays in FINISH; bist_start low -> IDLE; bist_start high -> new run with fail_mask cleared.
REQ-035 SHALL cover: reset=1 during RUN of channel 1 -> IDLE at the next edge with all outputs 0; a later start runs the full sequence from channel 0.
